// File: rtl/shape_cmd_sequencer_pkg.sv
// Shared types for the shape processor command sequencer.
// Also provides the control-word field extraction used for the readback compare.
package shape_pkg;

  localparam int SHAPE_MSB = 17;
  localparam int SHAPE_LSB = 16;
  localparam int OP_MSB    = 4;
  localparam int OP_LSB    = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  typedef struct packed {
    logic [SHAPE_MSB-SHAPE_LSB:0] shape;
    logic [OP_MSB-OP_LSB:0]       op;
  } ctrl_fields_t;

  function automatic ctrl_fields_t get_fields(input logic [31:0] word);
    ctrl_fields_t f;
    f.shape = word[SHAPE_MSB:SHAPE_LSB];
    f.op    = word[OP_MSB:OP_LSB];
    return f;
  endfunction

endpackage

// File: rtl/shape_cmd_sequencer_if.sv
// Command and response channels of the shape command sequencer.
interface shape_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_accepted;
  logic        rsp_error;
  logic [31:0] rsp_readback;

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_accepted, rsp_error, rsp_readback
  );

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_accepted, rsp_error, rsp_readback
  );
endinterface

// File: rtl/shape_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers.
// full/empty derive only from registered pointers, so a pop frees space one cycle later.
module shape_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/shape_cmd_sequencer.sv
// Issues buffered control words to the shape processor, reads the SFR back and
// reports whether the processor kept the written shape/operation fields.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a buffered command
// WRITE | one-cycle sp_write of cmd_q
// READ  | one-cycle sp_read of the SFR
// WAIT  | READ_LATENCY cycles until sp_read_data is valid, capture on the last
// RESP  | response presented until rsp_ready
module shape_cmd_sequencer
  import shape_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  shape_cmd_if.slave       bus,
  output logic             sp_write,
  output logic [31:0]      sp_write_data,
  output logic             sp_read,
  input  logic [31:0]      sp_read_data,
  input  logic             sp_error,
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] reject_cnt
);

  localparam logic [2:0] IDLE  = 3'(S_IDLE);
  localparam logic [2:0] WRITE = 3'(S_WRITE);
  localparam logic [2:0] READ  = 3'(S_READ);
  localparam logic [2:0] WAIT  = 3'(S_WAIT);
  localparam logic [2:0] RESP  = 3'(S_RESP);

  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

  logic [2:0]  state;
  logic [31:0] cmd_q;
  logic [1:0]  lat_cnt;
  logic [31:0] rsp_readback;
  logic        rsp_accepted;
  logic        rsp_error;

  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_pop;
  logic        rsp_hs;

  assign rsp_hs   = (state == RESP) && bus.rsp_ready;
  assign fifo_pop = !fifo_empty && ((state == IDLE) || rsp_hs);

  shape_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.cmd_valid && bus.cmd_ready),
    .push_data (bus.cmd_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cmd_q        <= '0;
      lat_cnt      <= '0;
      rsp_readback <= '0;
      rsp_accepted <= 1'b0;
      rsp_error    <= 1'b0;
      accept_cnt   <= '0;
      reject_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            cmd_q     <= fifo_data;
            rsp_error <= 1'b0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (sp_error) rsp_error <= 1'b1;
          state <= READ;
        end
        READ: begin
          if (sp_error) rsp_error <= 1'b1;
          lat_cnt <= LAT_INIT;
          state   <= WAIT;
        end
        WAIT: begin
          if (sp_error) rsp_error <= 1'b1;
          if (lat_cnt == 2'd0) begin
            rsp_readback <= sp_read_data;
            rsp_accepted <= (get_fields(sp_read_data) == get_fields(cmd_q));
            state        <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            // Counters stick at all-ones so software never sees a wrap.
            if (rsp_accepted) begin
              if (accept_cnt != '1) accept_cnt <= accept_cnt + CNT_W'(1);
            end else begin
              if (reject_cnt != '1) reject_cnt <= reject_cnt + CNT_W'(1);
            end
            if (fifo_pop) begin
              cmd_q     <= fifo_data;
              rsp_error <= 1'b0;
              state     <= WRITE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sp_write      = (state == WRITE);
  assign sp_write_data = sp_write ? cmd_q : 32'd0;
  assign sp_read       = (state == READ);

  assign bus.cmd_ready    = !fifo_full;
  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_accepted = rsp_accepted;
  assign bus.rsp_error    = rsp_error;
  assign bus.rsp_readback = rsp_readback;

endmodule

// File: tb/tb_shape_cmd_sequencer.sv
// Directed bench for shape_cmd_sequencer: stimulus queues expected writes and
// responses, a negedge monitor compares them as the DUT produces them.
module tb_shape_cmd_sequencer;
  import shape_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sp_write;
  logic [31:0] sp_write_data;
  logic        sp_read;
  logic [31:0] sp_read_data;
  logic        sp_error;
  logic [15:0] accept_cnt;
  logic [15:0] reject_cnt;

  shape_cmd_if bus();

  shape_cmd_sequencer #(
    .DEPTH        (4),
    .READ_LATENCY (1),
    .CNT_W        (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .sp_write      (sp_write),
    .sp_write_data (sp_write_data),
    .sp_read       (sp_read),
    .sp_read_data  (sp_read_data),
    .sp_error      (sp_error),
    .accept_cnt    (accept_cnt),
    .reject_cnt    (reject_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        acc;
    logic        err;
    logic [31:0] rb;
  } exp_t;

  exp_t        rsp_q[$];
  logic [31:0] wr_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_hs = -1;
  bit          check_spacing = 0;
  bit          err_arm = 0;
  bit          prev_write = 0;
  bit          held_valid = 0;
  exp_t        held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Shape processor model: only one-hot shapes are stored, read data one cycle after sp_read.
  logic [31:0] sfr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sfr          <= 32'd0;
      sp_read_data <= 32'd0;
    end else begin
      if (sp_write && (get_fields(sp_write_data).shape == 2'b01 ||
                       get_fields(sp_write_data).shape == 2'b10))
        sfr <= sp_write_data & 32'h0003_001F;
      if (sp_read)
        sp_read_data <= sfr;
    end
  end

  always @(negedge clk) begin
    if (err_arm && sp_read) begin
      sp_error = 1'b1;
      err_arm  = 1'b0;
    end else begin
      sp_error = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (prev_write) chk("read_after_write", 32'(sp_read), 32'd1);
      prev_write = sp_write;
      if (sp_write) begin
        chk("no_overlap_strobe", 32'(sp_read), 32'd0);
        if (wr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write: data 0x%08h with no command pending", sp_write_data);
        end else begin
          chk("write_data", sp_write_data, wr_q.pop_front());
        end
      end
      if (bus.rsp_valid) begin
        if (held_valid) begin
          chk("stable_accepted", 32'(bus.rsp_accepted), 32'(held.acc));
          chk("stable_error", 32'(bus.rsp_error), 32'(held.err));
          chk("stable_readback", bus.rsp_readback, held.rb);
        end
        if (bus.rsp_ready) begin
          held_valid = 0;
          if (rsp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_rsp: readback 0x%08h with no command pending", bus.rsp_readback);
          end else begin
            exp_t e;
            e = rsp_q.pop_front();
            chk("rsp_accepted", 32'(bus.rsp_accepted), 32'(e.acc));
            chk("rsp_error", 32'(bus.rsp_error), 32'(e.err));
            chk("rsp_readback", bus.rsp_readback, e.rb);
          end
          if (check_spacing) begin
            if (last_hs >= 0) chk("rsp_spacing", 32'(cyc - last_hs), 32'd4);
            last_hs = cyc;
          end
        end else begin
          held.acc   = bus.rsp_accepted;
          held.err   = bus.rsp_error;
          held.rb    = bus.rsp_readback;
          held_valid = 1;
        end
      end else begin
        held_valid = 0;
      end
    end else begin
      held_valid = 0;
      prev_write = 0;
    end
  end

  task automatic push_cmd(input logic [31:0] d, input logic acc, input logic [31:0] rb, input logic err);
    int n = 0;
    exp_t e;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout: cmd 0x%08h cmd_ready=%0b required 1", d, bus.cmd_ready);
    end else begin
      e.acc = acc; e.err = err; e.rb = rb;
      rsp_q.push_back(e);
      wr_q.push_back(d);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d responses still expected, required 0", rsp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 32'd0;
    bus.rsp_ready = 1'b1;
    #3;
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_sp_write", 32'(sp_write), 32'd0);
    chk("reset_sp_read", 32'(sp_read), 32'd0);
    chk("reset_accept_cnt", 32'(accept_cnt), 32'd0);
    chk("reset_reject_cnt", 32'(reject_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Legal command, then an illegal shape that the processor drops.
    push_cmd(32'h0001_0001, 1'b1, 32'h0001_0001, 1'b0);
    wait_drain();
    chk("cnt_accept_t1", 32'(accept_cnt), 32'd1);
    chk("cnt_reject_t1", 32'(reject_cnt), 32'd0);
    push_cmd(32'h0003_0000, 1'b0, 32'h0001_0001, 1'b0);
    wait_drain();
    chk("cnt_accept_t2", 32'(accept_cnt), 32'd1);
    chk("cnt_reject_t2", 32'(reject_cnt), 32'd1);

    // Back-pressure: one in flight plus four buffered, then full.
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    push_cmd(32'h0002_0003, 1'b1, 32'h0002_0003, 1'b0);
    push_cmd(32'hFFFD_0005, 1'b1, 32'h0001_0005, 1'b0);
    push_cmd(32'h0003_001F, 1'b0, 32'h0001_0005, 1'b0);
    push_cmd(32'h0000_0002, 1'b0, 32'h0001_0005, 1'b0);
    push_cmd(32'h0002_0010, 1'b1, 32'h0002_0010, 1'b0);
    @(negedge clk);
    chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("full_cmd_ready_hold", 32'(bus.cmd_ready), 32'd0);
    chk("full_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    fork
      push_cmd(32'h0001_0007, 1'b1, 32'h0001_0007, 1'b0);
      begin
        @(posedge clk);
        #1;
        last_hs       = -1;
        check_spacing = 1;
        bus.rsp_ready = 1'b1;
      end
    join
    wait_drain();
    check_spacing = 0;
    chk("cnt_accept_t3", 32'(accept_cnt), 32'd5);
    chk("cnt_reject_t3", 32'(reject_cnt), 32'd3);

    // Reset while the first command waits on readback and three are queued.
    fork
      begin
        push_cmd(32'h0001_0003, 1'b1, 32'h0001_0003, 1'b0);
        push_cmd(32'h0002_0004, 1'b1, 32'h0002_0004, 1'b0);
        push_cmd(32'h0001_0005, 1'b1, 32'h0001_0005, 1'b0);
        push_cmd(32'h0002_0006, 1'b1, 32'h0002_0006, 1'b0);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!sp_read && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (n >= 100) begin
          n_vec++; n_err++;
          $display("FAIL wait_sp_read: sp_read=%0b required 1", sp_read);
        end
        @(negedge clk);
        rst = 1'b1;
      end
    join
    #1;
    rsp_q.delete();
    wr_q.delete();
    chk("abort_sp_write", 32'(sp_write), 32'd0);
    chk("abort_sp_read", 32'(sp_read), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("abort_accept_cnt", 32'(accept_cnt), 32'd0);
    chk("abort_reject_cnt", 32'(reject_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_abort_accept_cnt", 32'(accept_cnt), 32'd0);

    // Processor error during READ on a legal command, clean transaction after.
    err_arm = 1'b1;
    push_cmd(32'h0002_0001, 1'b1, 32'h0002_0001, 1'b1);
    wait_drain();
    push_cmd(32'h0001_0002, 1'b1, 32'h0001_0002, 1'b0);
    wait_drain();
    chk("cnt_accept_t6", 32'(accept_cnt), 32'd2);
    chk("cnt_reject_t6", 32'(reject_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shape_cmd_sequencer.md
Name: shape_cmd_sequencer

Overview:
- Upstream command stage for the shape processor SFR.
- Accepts 32-bit control-word commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command as a one-cycle write to the processor, then reads the SFR back and compares the result against the command.
- Returns a per-command response (accepted/rejected plus readback) and keeps saturating accept/reject counters, so software learns whether the processor silently dropped an illegal write.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2
READ_LATENCY, 1, cycles from sp_read high to sp_read_data valid; 1..3
CNT_W, 16, width of accept/reject counters

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can take a command
cmd_data  in  32  control word; shape in [17:16], operation in [4:0]
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_accepted  out  1  readback matched command fields
rsp_error  out  1  sp_error seen during this transaction
rsp_readback  out  32  captured sp_read_data
sp_write  out  1  write strobe to shape processor
sp_write_data  out  32  write data to shape processor
sp_read  out  1  read strobe to shape processor
sp_read_data  in  32  SFR readback; shape [17:16], operation [4:0], other bits 0
sp_error  in  1  processor error
accept_cnt  out  CNT_W  saturating count of accepted commands
reject_cnt  out  CNT_W  saturating count of rejected commands

Behaviour:
- Reset (async on rst high): FIFO empty, FSM in IDLE, all outputs 0 except cmd_ready=1.
  - Reset mid-transaction aborts it: no response, strobes drop immediately, FIFO contents discarded.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full, registered.
  - A pop in the same cycle does not free space until the next cycle. So with the FIFO full, a simultaneous push is refused (cmd_ready already 0).
  - Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
- FSM states: IDLE, WRITE, READ, WAIT, RESP.
  - IDLE: if FIFO non-empty, pop head into cmd_q and go to WRITE; else stay.
  - WRITE: sp_write=1 and sp_write_data=cmd_q for exactly one cycle; then READ.
  - READ: sp_read=1 for exactly one cycle; then WAIT.
  - WAIT: counts READ_LATENCY cycles. On the last, capture sp_read_data into rsp_readback and compute rsp_accepted = (readback[17:16]==cmd_q[17:16]) && (readback[4:0]==cmd_q[4:0]). Then RESP.
  - RESP: rsp_valid=1. rsp_* fields are stable while rsp_valid && !rsp_ready.
    - On handshake, increment accept_cnt or reject_cnt.
    - On handshake, go to WRITE with a pop if the FIFO is non-empty, else IDLE.
- Minimum command spacing: 3 + READ_LATENCY cycles when rsp_ready is held 1.
- rsp_error: cleared on entering WRITE; set if sp_error is high in any cycle of WRITE, READ or WAIT. It is independent of rsp_accepted.
- Unused cmd_data bits are passed through to sp_write_data unchanged and ignored in the compare.
- Counters saturate at all-ones and never wrap.
- sp_write and sp_read are never high in the same cycle. Neither is high outside WRITE/READ.

Decomposition:
- Package shape_pkg holds:
  - state enum
  - localparams SHAPE_MSB=17, SHAPE_LSB=16, OP_MSB=4, OP_LSB=0
  - typedef of a ctrl-word field struct, plus a field-extract function reused by the bench
- One sub-module, shape_cmd_fifo: a parameterised synchronous FIFO (DEPTH, width 32) with push/pop/full/empty.

Test Plan:
- After reset, cmd 0x0001_0001 (shape 01, op 00001), rsp_ready=1 -> sp_write pulse with 0x0001_0001, sp_read next cycle, rsp_valid with rsp_accepted=1, rsp_readback=0x0001_0001, accept_cnt=1.
- cmd 0x0003_0000 (non-onehot shape) after the previous cmd -> processor keeps old value; rsp_accepted=0, rsp_readback=0x0001_0001, reject_cnt=1.
- rsp_ready=0, push cmds continuously -> 1 in flight + DEPTH buffered (5 accepted), then cmd_ready=0. The RESP fields stay stable. Releasing rsp_ready drains in order, one response per 4 cycles.
- With FIFO full, cmd_valid=1 on the same cycle as a pop -> no push that cycle. The push occurs the next cycle and no command is lost or duplicated.
- Assert rst during WAIT with 3 cmds queued -> strobes and rsp_valid drop immediately, cmd_ready=1, no response ever emitted for aborted or queued cmds, counters 0.
- sp_error pulsed during READ on a legal cmd -> rsp_error=1, rsp_accepted=1. The next transaction has rsp_error=0.
